mole_ring_gen: RTL
==================

MOLE_RING_GEN -- requirements
Module: mole_ring_gen

Interface
REQ-001 Parameter N, default 10: number of mole positions (LEDs); legal range 2..32.
REQ-002 Parameter PW, default 8: width of the period input.
REQ-003 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 ring_reset  input  1  synchronous, active-high reset.
REQ-006 ring_en  input  1  run enable; when low, all state holds.
REQ-007 mode  input  2  00 rotate-up, 01 rotate-down, 10 bounce, 11 random.
REQ-008 period  input  PW  step interval; the mole advances every period+1 enabled cycles.
REQ-009 hit_btn  input  N  player buttons, one per position, already synchronised and debounced.
REQ-010 mole_posit  output  N  registered one-hot mole position.
REQ-011 step  output  1  one-cycle pulse, coincident with each change of mole_posit.
REQ-012 hit  output  1  one-cycle pulse for a correct press.
REQ-013 miss  output  1  one-cycle pulse for a wrong press.

Function
REQ-014 State: position index pos (0..N-1), prescaler cnt (PW bits), direction dir (up/down), 16-bit LFSR; mole_posit = 1<<pos at all times.
REQ-015 Tick: when ring_en=1 and cnt>=period, this is a tick cycle; cnt returns to 0 and the block advances. Otherwise, when ring_en=1, cnt increments. The >= compare means a lowered period takes effect on the next enabled cycle.
REQ-016 Mode 00 advance: pos wraps from N-1 to 0; otherwise pos+1.
REQ-017 Mode 01 advance: pos wraps from 0 to N-1; otherwise pos-1.
REQ-018 Mode 10 advance: pos moves one place in direction dir; at pos=N-1 with dir=up, pos becomes N-2 and dir flips to down. The mirror rule applies at pos=0 with dir=down. The mole stays on each end position for one step only.
REQ-019 In modes 00, 01 and 11, dir is forced to up, so entering bounce always starts upward.
REQ-020 Mode 11 advance: candidate = the low ceil(log2 N) LFSR bits. If candidate>=N, subtract N once. If the result equals pos, use (result+1) wrapped to N. The position therefore always changes and stays below N.
REQ-021 LFSR: Fibonacci, taps 16,14,13,11; shifts every cycle that ring_en=1; holds when ring_en=0.
REQ-022 A mode change takes effect at the next advance; pos is not altered at the moment of the change.
REQ-023 Press evaluation: on a cycle with ring_en=1 and hit_btn!=0, the block evaluates the press.
  - Any overlap of hit_btn and mole_posit: hit=1 next cycle, miss=0.
  - No overlap: miss=1 next cycle, hit=0.
  - A press with several buttons held that includes the mole position counts as a hit.
REQ-024 A hit forces an advance on the same edge and clears cnt to 0. A hit coinciding with a tick produces exactly one advance.
REQ-025 A miss does not move the mole and does not disturb cnt.
REQ-026 Latency: the advance, step, hit and miss caused by cycle t inputs are all visible at cycle t+1.
REQ-027 ring_en=0: pos, cnt, dir and LFSR hold; step, hit and miss are 0; hit_btn is ignored.
REQ-028 step is 1 exactly on the cycle after an advance, whether the advance came from a tick or from a hit.

Reset
REQ-029 On a rising edge with ring_reset=1, the block loads: pos=0 (mole_posit=1), cnt=0, dir=up, LFSR=SEED, step=hit=miss=0.
REQ-030 ring_reset has priority over ring_en, hit_btn and tick.
REQ-031 A reset applied mid-operation restarts the sequence identically, random mode included.

Verification (N=10, PW=8)
REQ-032 Reset: hold ring_reset high for 2 cycles -> mole_posit=10'b0000000001; step, hit and miss all 0.
REQ-033 Rotate and freeze (mode=00, period=0, ring_en=1, 12 cycles):
  - mole_posit steps 0x001, 0x002, ... 0x200, 0x001, one step per cycle, with step high on every cycle.
  - Then ring_en=0 for 3 cycles -> mole_posit holds and step=0.
REQ-034 Bounce (mode=10, period=1): pos sequence is 0,1,...,9,8,...,0,1, advancing every 2nd cycle.
REQ-035 Random (mode=11, period=0, 1000 steps): every mole_posit is one-hot, pos<10, and each pos differs from the previous one. A reset then repeat reproduces the identical sequence.
REQ-036 Hit and miss (mode=00, period=20):
  - With mole_posit=0x004, pulse hit_btn=0x004 for 1 cycle -> next cycle hit=1, step=1, mole_posit=0x008, cnt=0.
  - Then pulse hit_btn=0x001 -> miss=1, mole_posit stays 0x008.
REQ-037 Collision: a hit in a tick cycle -> single advance, one step pulse.

Source files
------------

// File: rtl/mole_ring_gen_if.sv
// Bus bundle for the mole ring generator: run controls, player buttons and
// the registered mole position / event pulses.
interface mole_ring_gen_if #(
  parameter int N  = 10,
  parameter int PW = 8
);
  logic          ring_en;
  logic [1:0]    mode;
  logic [PW-1:0] period;
  logic [N-1:0]  hit_btn;
  logic [N-1:0]  mole_posit;
  logic          step;
  logic          hit;
  logic          miss;

  // Game controller / player side: drives controls, observes the mole.
  modport master (
    output ring_en, mode, period, hit_btn,
    input  mole_posit, step, hit, miss
  );

  // Generator side.
  modport slave (
    input  ring_en, mode, period, hit_btn,
    output mole_posit, step, hit, miss
  );
endinterface

// File: rtl/mole_ring_gen.sv
// Whack-a-mole position generator: a one-hot mole that rotates up, rotates
// down, bounces between the ends or jumps pseudo-randomly, advancing every
// period+1 enabled cycles or immediately when the player hits it.
module mole_ring_gen #(
  parameter int          N    = 10,
  parameter int          PW   = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            ring_reset,
  mole_ring_gen_if.slave  bus
);

  localparam int PIW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PIW-1:0] LAST = PIW'(N - 1);
  localparam logic [PIW:0]   N_W  = (PIW + 1)'(N);
  // Truncation is harmless: the fold below only runs when the raw value is
  // at least N, which cannot happen when N is an exact power of two.
  localparam logic [PIW-1:0] N_L  = PIW'(N);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RANDOM = 2'b11;

  logic [PIW-1:0] pos_reg,   pos_next;
  logic [PW-1:0]  cnt_reg,   cnt_next;
  logic           dir_reg,   dir_next;
  logic [15:0]    lfsr_reg,  lfsr_next;
  logic [N-1:0]   posit_reg, posit_next;
  logic           step_reg,  step_next;
  logic           hit_reg,   hit_next;
  logic           miss_reg,  miss_next;

  logic           press;
  logic           overlap;
  logic           is_hit;
  logic           is_miss;
  logic           tick;
  logic           advance;
  logic [PIW-1:0] adv_pos;
  logic           adv_dir;
  logic [PIW:0]   rnd_raw;
  logic [PIW-1:0] rnd_low;
  logic [PIW-1:0] rnd_fold;
  logic [PIW-1:0] rnd_pos;
  logic           lfsr_fb;

  // Press and tick qualification; both require the block to be enabled.
  always_comb begin
    press   = bus.ring_en && (bus.hit_btn != '0);
    overlap = (bus.hit_btn & posit_reg) != '0;
    is_hit  = press && overlap;
    is_miss = press && !overlap;
    tick    = bus.ring_en && (cnt_reg >= bus.period);
    // A hit landing on a tick still yields exactly one advance.
    advance = tick || is_hit;
  end

  // Random candidate: low LFSR bits folded once into 0..N-1, then nudged
  // forward if it would leave the mole where it already is.
  always_comb begin
    rnd_low  = lfsr_reg[PIW-1:0];
    rnd_raw  = {1'b0, rnd_low};
    rnd_fold = (rnd_raw >= N_W) ? (rnd_low - N_L) : rnd_low;
    rnd_pos  = rnd_fold;
    if (rnd_fold == pos_reg) begin
      rnd_pos = (rnd_fold == LAST) ? '0 : (rnd_fold + 1'b1);
    end
  end

  // Fibonacci LFSR feedback, taps 16/14/13/11.
  always_comb begin
    lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  end

  // Where the mole goes (and which way bounce faces) if this cycle advances.
  always_comb begin
    adv_pos = pos_reg;
    adv_dir = DIR_UP;
    case (bus.mode)
      MODE_UP: begin
        adv_pos = (pos_reg == LAST) ? '0 : (pos_reg + 1'b1);
      end
      MODE_DOWN: begin
        adv_pos = (pos_reg == '0) ? LAST : (pos_reg - 1'b1);
      end
      MODE_BOUNCE: begin
        if (dir_reg == DIR_UP) begin
          if (pos_reg == LAST) begin
            adv_pos = LAST - 1'b1;
            adv_dir = DIR_DOWN;
          end else begin
            adv_pos = pos_reg + 1'b1;
            adv_dir = DIR_UP;
          end
        end else begin
          if (pos_reg == '0) begin
            adv_pos = {{(PIW-1){1'b0}}, 1'b1};
            adv_dir = DIR_UP;
          end else begin
            adv_pos = pos_reg - 1'b1;
            adv_dir = DIR_DOWN;
          end
        end
      end
      MODE_RANDOM: begin
        adv_pos = rnd_pos;
      end
      default: begin
        adv_pos = pos_reg;
      end
    endcase
  end

  // Next-state logic: everything holds and pulses drop while disabled.
  always_comb begin
    pos_next  = pos_reg;
    cnt_next  = cnt_reg;
    dir_next  = dir_reg;
    lfsr_next = lfsr_reg;
    step_next = 1'b0;
    hit_next  = 1'b0;
    miss_next = 1'b0;
    if (bus.ring_en) begin
      lfsr_next = {lfsr_reg[14:0], lfsr_fb};
      if (bus.mode != MODE_BOUNCE) begin
        dir_next = DIR_UP;
      end
      if (advance) begin
        pos_next  = adv_pos;
        dir_next  = adv_dir;
        cnt_next  = '0;
        step_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      hit_next  = is_hit;
      miss_next = is_miss;
    end
  end

  // One-hot decode of the next position so mole_posit comes from a register.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign posit_next[gi] = (pos_next == PIW'(gi));
    end
  endgenerate

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (ring_reset) begin
      pos_reg   <= '0;
      cnt_reg   <= '0;
      dir_reg   <= DIR_UP;
      lfsr_reg  <= SEED;
      posit_reg <= {{(N-1){1'b0}}, 1'b1};
      step_reg  <= 1'b0;
      hit_reg   <= 1'b0;
      miss_reg  <= 1'b0;
    end else begin
      pos_reg   <= pos_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      lfsr_reg  <= lfsr_next;
      posit_reg <= posit_next;
      step_reg  <= step_next;
      hit_reg   <= hit_next;
      miss_reg  <= miss_next;
    end
  end

  // Outputs are straight from registers.
  assign bus.mole_posit = posit_reg;
  assign bus.step       = step_reg;
  assign bus.hit        = hit_reg;
  assign bus.miss       = miss_reg;

endmodule
